// File: rtl/axi4_fifo_bridge_if.sv
// AXI4 slave-side bundle between an AXI master and the FIFO bridge.
// No logic, wires only.
// Handshakes are plain AXI valid/ready on each of the five channels.
interface axi4_fifo_bridge_if #(
  parameter int ID_W   = 4,
  parameter int AXI_DW = 64
);
  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid, wready;
  logic [AXI_DW-1:0] wdata;
  logic [AXI_DW/8-1:0] wstrb;
  logic              wlast;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [ID_W-1:0]   rid;
  logic [AXI_DW-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );
endinterface

// File: rtl/axi4_fifo_bridge.sv
// AXI4 slave to FIFO-cache command bridge: packs RATIO beats per FIFO word, unpacks read words.
// Latency: address taken in 1 cycle; write cmd the cycle after a word fills; R beat the cycle after a word lands.
// Backpressure: all outputs held while valid & !ready; one AXI transaction in flight at a time.
module axi4_fifo_bridge #(
  parameter int AXI_DW  = 64,
  parameter int FIFO_DW = 128,
  parameter int ID_W    = 4,
  parameter int FADDR_W = 27,
  parameter int CNT_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  axi4_fifo_bridge_if.slave    io_axi4,
  output logic                 fifo_cmd_valid,
  input  logic                 fifo_cmd_ready,
  output logic                 fifo_cmd_type,
  output logic [FADDR_W-1:0]   fifo_cmd_addr,
  output logic [CNT_W-1:0]     fifo_cmd_burst_cnt,
  output logic [FIFO_DW-1:0]   fifo_cmd_wt_data,
  output logic [FIFO_DW/8-1:0] fifo_cmd_wt_mask,
  input  logic                 fifo_rsp_valid,
  output logic                 fifo_rsp_ready,
  input  logic [FIFO_DW-1:0]   fifo_rsp_data
);
  localparam int RATIO    = FIFO_DW / AXI_DW;
  localparam int AXI_BY   = AXI_DW / 8;
  localparam int AXI_BB   = $clog2(AXI_BY);
  localparam int FIFO_BB  = $clog2(FIFO_DW / 8);
  localparam int RATIO_SH = $clog2(RATIO);
  localparam int LANE_W   = (RATIO > 1) ? RATIO_SH : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
  localparam logic [9:0]        MAX_WORDS = 10'((1 << CNT_W) - 1);

  typedef enum logic [2:0] {
    IDLE, WR_PACK, WR_CMD, WR_RESP, WR_DRAIN, RD_CMD, RD_DATA, RD_ERR
  } state_t;

  state_t               state, state_nxt;
  logic                 prio_wr;
  logic [ID_W-1:0]      id_q;
  logic [FADDR_W-1:0]   addr_q;
  logic [7:0]           len_q, beat_q;
  logic [LANE_W-1:0]    lane_q, lane_inc;
  logic [CNT_W-1:0]     cnt_q, words_left_q;
  logic                 err_q, wdone_q, rbuf_vld_q;
  logic [FIFO_DW-1:0]   wbuf_q, rbuf_q;
  logic [FIFO_DW/8-1:0] wmask_q;
  logic [AXI_DW-1:0]    rd_lane;

  logic                 gnt_wr, gnt_rd, legal_base, legal_rd;
  logic [31:0]          sel_addr;
  logic [7:0]           sel_len;
  logic [2:0]           sel_size;
  logic [1:0]           sel_burst;
  logic [ID_W-1:0]      sel_id;
  logic [LANE_W-1:0]    sel_lane0;
  logic [13:0]          end_off;
  logic [9:0]           n_words;

  // Round-robin grant between AW and AR, and legality of the granted burst
  always_comb begin
    gnt_wr     = io_axi4.awvalid && (prio_wr || !io_axi4.arvalid);
    gnt_rd     = io_axi4.arvalid && !gnt_wr;
    sel_addr   = gnt_wr ? io_axi4.awaddr  : io_axi4.araddr;
    sel_len    = gnt_wr ? io_axi4.awlen   : io_axi4.arlen;
    sel_size   = gnt_wr ? io_axi4.awsize  : io_axi4.arsize;
    sel_burst  = gnt_wr ? io_axi4.awburst : io_axi4.arburst;
    sel_id     = gnt_wr ? io_axi4.awid    : io_axi4.arid;
    sel_lane0  = LANE_W'((sel_addr >> AXI_BB) & 32'(RATIO - 1));
    end_off    = 14'(sel_addr[11:0]) + ((14'(sel_len) + 14'd1) << AXI_BB);
    n_words    = (10'(sel_lane0) + 10'(sel_len) + 10'(RATIO)) >> RATIO_SH;
    legal_base = (sel_burst == 2'b01) && (sel_size == 3'(AXI_BB)) && (end_off <= 14'd4096);
    legal_rd   = legal_base && (n_words <= MAX_WORDS);
    lane_inc   = (lane_q == LANE_LAST) ? '0 : lane_q + LANE_W'(1);
  end

  // Select the lane of the held read word that the current R beat carries
  always_comb begin
    rd_lane = '0;
    for (int l = 0; l < RATIO; l++)
      if (LANE_W'(l) == lane_q) rd_lane = rbuf_q[l*AXI_DW +: AXI_DW];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and all handshake/bus outputs, zero unless the state drives them
  always_comb begin
    state_nxt          = state;
    io_axi4.awready    = 1'b0;
    io_axi4.arready    = 1'b0;
    io_axi4.wready     = 1'b0;
    io_axi4.bvalid     = 1'b0;
    io_axi4.bid        = '0;
    io_axi4.bresp      = 2'b00;
    io_axi4.rvalid     = 1'b0;
    io_axi4.rid        = '0;
    io_axi4.rdata      = '0;
    io_axi4.rresp      = 2'b00;
    io_axi4.rlast      = 1'b0;
    fifo_cmd_valid     = 1'b0;
    fifo_cmd_type      = 1'b0;
    fifo_cmd_addr      = '0;
    fifo_cmd_burst_cnt = '0;
    fifo_cmd_wt_data   = '0;
    fifo_cmd_wt_mask   = '0;
    fifo_rsp_ready     = 1'b0;
    case (state)
      IDLE: begin
        io_axi4.awready = gnt_wr;
        io_axi4.arready = gnt_rd;
        if (gnt_wr)      state_nxt = legal_base ? WR_PACK : WR_DRAIN;
        else if (gnt_rd) state_nxt = legal_rd ? RD_CMD : RD_ERR;
      end
      WR_PACK: begin
        io_axi4.wready = 1'b1;
        if (io_axi4.wvalid && (lane_q == LANE_LAST || io_axi4.wlast)) state_nxt = WR_CMD;
      end
      WR_CMD: begin
        fifo_cmd_valid     = 1'b1;
        fifo_cmd_addr      = addr_q;
        fifo_cmd_burst_cnt = CNT_W'(1);
        fifo_cmd_wt_data   = wbuf_q;
        fifo_cmd_wt_mask   = wmask_q;
        if (fifo_cmd_ready) state_nxt = wdone_q ? WR_RESP : WR_PACK;
      end
      WR_DRAIN: begin
        io_axi4.wready = 1'b1;
        if (io_axi4.wvalid && io_axi4.wlast) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        io_axi4.bvalid = 1'b1;
        io_axi4.bid    = id_q;
        io_axi4.bresp  = err_q ? 2'b10 : 2'b00;
        if (io_axi4.bready) state_nxt = IDLE;
      end
      RD_CMD: begin
        fifo_cmd_valid     = 1'b1;
        fifo_cmd_type      = 1'b1;
        fifo_cmd_addr      = addr_q;
        fifo_cmd_burst_cnt = cnt_q;
        if (fifo_cmd_ready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        fifo_rsp_ready = !rbuf_vld_q && (words_left_q != '0);
        io_axi4.rvalid = rbuf_vld_q;
        io_axi4.rid    = rbuf_vld_q ? id_q : '0;
        io_axi4.rdata  = rbuf_vld_q ? rd_lane : '0;
        io_axi4.rlast  = rbuf_vld_q && (beat_q == len_q);
        if (rbuf_vld_q && io_axi4.rready && beat_q == len_q) state_nxt = IDLE;
      end
      RD_ERR: begin
        io_axi4.rvalid = 1'b1;
        io_axi4.rid    = id_q;
        io_axi4.rresp  = 2'b10;
        io_axi4.rlast  = (beat_q == len_q);
        if (io_axi4.rready && beat_q == len_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context, write packing buffer and read holding buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_wr      <= 1'b1;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      lane_q       <= '0;
      cnt_q        <= '0;
      words_left_q <= '0;
      err_q        <= 1'b0;
      wdone_q      <= 1'b0;
      rbuf_vld_q   <= 1'b0;
      wbuf_q       <= '0;
      wmask_q      <= '1;
      rbuf_q       <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_wr || gnt_rd) begin
          prio_wr      <= gnt_rd;
          id_q         <= sel_id;
          addr_q       <= FADDR_W'(sel_addr >> FIFO_BB);
          len_q        <= sel_len;
          beat_q       <= '0;
          lane_q       <= sel_lane0;
          cnt_q        <= CNT_W'(n_words);
          words_left_q <= CNT_W'(n_words);
          err_q        <= gnt_wr ? !legal_base : !legal_rd;
          wdone_q      <= 1'b0;
          rbuf_vld_q   <= 1'b0;
          wbuf_q       <= '0;
          wmask_q      <= '1;
        end
        WR_PACK: if (io_axi4.wvalid) begin
          for (int l = 0; l < RATIO; l++)
            if (LANE_W'(l) == lane_q) begin
              wbuf_q[l*AXI_DW +: AXI_DW]  <= io_axi4.wdata;
              wmask_q[l*AXI_BY +: AXI_BY] <= wmask_q[l*AXI_BY +: AXI_BY] & ~io_axi4.wstrb;
            end
          lane_q  <= lane_inc;
          wdone_q <= io_axi4.wlast;
        end
        WR_CMD: if (fifo_cmd_ready) begin
          addr_q  <= addr_q + FADDR_W'(1);
          wbuf_q  <= '0;
          wmask_q <= '1;
        end
        RD_DATA: begin
          if (fifo_rsp_valid && fifo_rsp_ready) begin
            rbuf_q       <= fifo_rsp_data;
            rbuf_vld_q   <= 1'b1;
            words_left_q <= words_left_q - CNT_W'(1);
          end
          if (rbuf_vld_q && io_axi4.rready) begin
            beat_q <= beat_q + 8'd1;
            lane_q <= lane_inc;
            if (lane_q == LANE_LAST || beat_q == len_q) rbuf_vld_q <= 1'b0;
          end
        end
        RD_ERR: if (io_axi4.rready) beat_q <= beat_q + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_fifo_bridge.sv
// Directed bench for axi4_fifo_bridge (AXI 64 -> FIFO 128).
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
// A small FIFO responder returns queued read words; monitors log commands and R beats.
module tb_axi4_fifo_bridge;
  logic clk, rst;
  logic          fifo_cmd_valid, fifo_cmd_ready, fifo_cmd_type;
  logic [26:0]   fifo_cmd_addr;
  logic [5:0]    fifo_cmd_burst_cnt;
  logic [127:0]  fifo_cmd_wt_data;
  logic [15:0]   fifo_cmd_wt_mask;
  logic          fifo_rsp_valid, fifo_rsp_ready;
  logic [127:0]  fifo_rsp_data;

  axi4_fifo_bridge_if #(.ID_W(4), .AXI_DW(64)) axi ();

  axi4_fifo_bridge #(.AXI_DW(64), .FIFO_DW(128), .ID_W(4), .FADDR_W(27), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .io_axi4(axi),
    .fifo_cmd_valid(fifo_cmd_valid), .fifo_cmd_ready(fifo_cmd_ready),
    .fifo_cmd_type(fifo_cmd_type), .fifo_cmd_addr(fifo_cmd_addr),
    .fifo_cmd_burst_cnt(fifo_cmd_burst_cnt), .fifo_cmd_wt_data(fifo_cmd_wt_data),
    .fifo_cmd_wt_mask(fifo_cmd_wt_mask), .fifo_rsp_valid(fifo_rsp_valid),
    .fifo_rsp_ready(fifo_rsp_ready), .fifo_rsp_data(fifo_rsp_data)
  );

  typedef struct packed {
    logic typ; logic [26:0] addr; logic [5:0] cnt; logic [127:0] data; logic [15:0] mask;
  } cmd_t;
  typedef struct packed {
    logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;
  } rbeat_t;

  cmd_t         cmd_q[$];
  rbeat_t       r_q[$];
  logic [127:0] rsp_q[$];
  int           cmd_valid_cycles;
  int           n_cmp, n_bad;
  logic         rsp_fire;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (fifo_cmd_valid) cmd_valid_cycles++;
    if (fifo_cmd_valid && fifo_cmd_ready)
      cmd_q.push_back({fifo_cmd_type, fifo_cmd_addr, fifo_cmd_burst_cnt, fifo_cmd_wt_data, fifo_cmd_wt_mask});
    if (axi.rvalid && axi.rready)
      r_q.push_back({axi.rid, axi.rdata, axi.rresp, axi.rlast});
  end

  initial begin
    fifo_rsp_valid = 1'b0;
    fifo_rsp_data  = '0;
    forever begin
      @(negedge clk);
      rsp_fire = fifo_rsp_valid && fifo_rsp_ready;
      @(posedge clk);
      #1;
      if (rsp_fire && rsp_q.size() > 0) void'(rsp_q.pop_front());
      fifo_rsp_valid = (rsp_q.size() > 0);
      fifo_rsp_data  = (rsp_q.size() > 0) ? rsp_q[0] : '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr;
    axi.awlen = len; axi.awsize = 3'd3; axi.awburst = burst;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr;
    axi.arlen = len; axi.arsize = 3'd3; axi.arburst = 2'b01;
  endtask

  task automatic wait_aw();
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = axi.awready; tick();
    end
    axi.awvalid = 1'b0;
    chk("aw_accept", ok, 1);
  endtask

  task automatic wait_ar();
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = axi.arready; tick();
    end
    axi.arvalid = 1'b0;
    chk("ar_accept", ok, 1);
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    logic ok = 1'b0;
    axi.wvalid = 1'b1; axi.wdata = d; axi.wstrb = s; axi.wlast = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = axi.wready; tick();
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    chk("w_accept", ok, 1);
  endtask

  task automatic wait_b(input logic [3:0] id, input logic [1:0] resp);
    logic ok = 1'b0;
    logic [3:0] bid = '0;
    logic [1:0] br = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = axi.bvalid; bid = axi.bid; br = axi.bresp; tick();
    end
    chk("b_seen", ok, 1);
    chk("bid", bid, id);
    chk("bresp", br, resp);
  endtask

  task automatic wait_r(input int n);
    for (int i = 0; i < 2000 && r_q.size() < n; i++) tick();
    chk("r_count", r_q.size(), n);
  endtask

  task automatic wait_rvalid();
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = axi.rvalid;
      if (!ok) tick();
    end
    chk("rvalid_seen", ok, 1);
  endtask

  initial begin
    logic [63:0] wd [4];
    int c0, bad, lasts;
    wd[0] = 64'h0123456789ABCDEF; wd[1] = 64'h1122334455667788;
    wd[2] = 64'h99AABBCCDDEEFF00; wd[3] = 64'h0F1E2D3C4B5A6978;
    n_cmp = 0; n_bad = 0; cmd_valid_cycles = 0;
    rst = 1'b1; fifo_cmd_ready = 1'b1;
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 1;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    axi.rready = 1;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_awready", axi.awready, 0);  chk("rst_arready", axi.arready, 0);
    chk("rst_wready", axi.wready, 0);    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);    chk("rst_bresp", axi.bresp, 0);
    chk("rst_rresp", axi.rresp, 0);      chk("rst_cmd_valid", fifo_cmd_valid, 0);
    chk("rst_rsp_ready", fifo_rsp_ready, 0); chk("rst_cmd_addr", fifo_cmd_addr, 0);
    chk("rst_cmd_mask", fifo_cmd_wt_mask, 0); chk("rst_cmd_cnt", fifo_cmd_burst_cnt, 0);
    tick(); rst = 1'b0; tick();

    // T1: 4-beat aligned write -> two full words
    cmd_q.delete();
    set_aw(4'd3, 32'h100, 8'd3, 2'b01); wait_aw();
    for (int k = 0; k < 4; k++) send_w(wd[k], 8'hFF, k == 3);
    wait_b(4'd3, 2'b00);
    chk("t1_ncmd", cmd_q.size(), 2);
    chk("t1_c0_type", cmd_q[0].typ, 0);   chk("t1_c0_addr", cmd_q[0].addr, 27'h10);
    chk("t1_c0_cnt", cmd_q[0].cnt, 1);    chk("t1_c0_mask", cmd_q[0].mask, 16'h0000);
    chk("t1_c0_data", cmd_q[0].data, {wd[1], wd[0]});
    chk("t1_c1_addr", cmd_q[1].addr, 27'h11); chk("t1_c1_mask", cmd_q[1].mask, 16'h0000);
    chk("t1_c1_data", cmd_q[1].data, {wd[3], wd[2]});

    // T2: single beat into upper lane, partial strobe
    cmd_q.delete();
    set_aw(4'd2, 32'h108, 8'd0, 2'b01); wait_aw();
    send_w(64'hAABBCCDD11223344, 8'h0F, 1'b1);
    wait_b(4'd2, 2'b00);
    chk("t2_ncmd", cmd_q.size(), 1);
    chk("t2_addr", cmd_q[0].addr, 27'h10);
    chk("t2_mask", cmd_q[0].mask, 16'hF0FF);
    chk("t2_data", cmd_q[0].data, 128'hAABBCCDD11223344_0000000000000000);

    // T3: read starting at lane 1, 3 beats over 2 words
    cmd_q.delete(); r_q.delete();
    rsp_q.push_back(128'hA1A1A1A1A1A1A1A1_A0A0A0A0A0A0A0A0);
    rsp_q.push_back(128'hB1B1B1B1B1B1B1B1_B0B0B0B0B0B0B0B0);
    set_ar(4'd5, 32'h208, 8'd2); wait_ar();
    wait_r(3);
    chk("t3_ncmd", cmd_q.size(), 1);
    chk("t3_type", cmd_q[0].typ, 1); chk("t3_addr", cmd_q[0].addr, 27'h20);
    chk("t3_cnt", cmd_q[0].cnt, 2);
    chk("t3_b0", r_q[0].data, 64'hA1A1A1A1A1A1A1A1);
    chk("t3_b1", r_q[1].data, 64'hB0B0B0B0B0B0B0B0);
    chk("t3_b2", r_q[2].data, 64'hB1B1B1B1B1B1B1B1);
    chk("t3_last", {r_q[0].last, r_q[1].last, r_q[2].last}, 3'b001);
    chk("t3_rid", r_q[2].id, 4'd5); chk("t3_rresp", r_q[2].resp, 2'b00);
    tick();

    // T4a: AW and AR together after reset history -> write first
    r_q.delete();
    rsp_q.push_back(128'hD1D1D1D1D1D1D1D1_D0D0D0D0D0D0D0D0);
    set_aw(4'd1, 32'h300, 8'd1, 2'b01); set_ar(4'd2, 32'h400, 8'd1);
    @(negedge clk);
    chk("t4a_awready", axi.awready, 1); chk("t4a_arready", axi.arready, 0);
    tick(); axi.awvalid = 1'b0;
    send_w(wd[0], 8'hFF, 1'b0); send_w(wd[1], 8'hFF, 1'b1);
    wait_b(4'd1, 2'b00);
    wait_ar(); wait_r(2);
    chk("t4a_r1", r_q[1].data, 64'hD1D1D1D1D1D1D1D1);

    // T4b: last grant was write -> both valid grants read first
    set_aw(4'd6, 32'h500, 8'd0, 2'b01); wait_aw();
    send_w(wd[2], 8'hFF, 1'b1); wait_b(4'd6, 2'b00);
    r_q.delete();
    rsp_q.push_back(128'hE1E1E1E1E1E1E1E1_E0E0E0E0E0E0E0E0);
    set_aw(4'd1, 32'h510, 8'd0, 2'b01); set_ar(4'd3, 32'h520, 8'd0);
    @(negedge clk);
    chk("t4b_arready", axi.arready, 1); chk("t4b_awready", axi.awready, 0);
    tick(); axi.arvalid = 1'b0;
    wait_r(1);
    chk("t4b_r0", r_q[0].data, 64'hE0E0E0E0E0E0E0E0);
    wait_aw(); send_w(wd[3], 8'hFF, 1'b1); wait_b(4'd1, 2'b00);

    // T5: WRAP write drained with SLVERR, oversize and 4KB-crossing reads error out
    c0 = cmd_valid_cycles;
    set_aw(4'd7, 32'h100, 8'd3, 2'b10); wait_aw();
    for (int k = 0; k < 4; k++) send_w(wd[k], 8'hFF, k == 3);
    wait_b(4'd7, 2'b10);
    r_q.delete();
    set_ar(4'd8, 32'h0, 8'd255); wait_ar();
    wait_r(256);
    bad = 0; lasts = 0;
    foreach (r_q[i]) begin
      if (r_q[i].resp != 2'b10 || r_q[i].data != 64'd0 || r_q[i].id != 4'd8) bad++;
      if (r_q[i].last) lasts++;
    end
    chk("t5_err_beats_bad", bad, 0);
    chk("t5_rlast_count", lasts, 1);
    chk("t5_rlast_pos", r_q[255].last, 1);
    r_q.delete();
    set_ar(4'd4, 32'hFF8, 8'd1); wait_ar();
    wait_r(2);
    chk("t5_4k_resp", {r_q[0].resp, r_q[1].resp}, 4'b1010);
    chk("t5_4k_last", r_q[1].last, 1);
    chk("t5_no_cmd", cmd_valid_cycles - c0, 0);

    // T6: command stall, R stall with rready toggling, reset mid-burst
    fifo_cmd_ready = 1'b0;
    set_aw(4'd9, 32'h600, 8'd1, 2'b01); wait_aw();
    send_w(wd[0], 8'hFF, 1'b0); send_w(wd[1], 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_stall_valid", fifo_cmd_valid, 1);
      chk("t6_stall_data", fifo_cmd_wt_data, {wd[1], wd[0]});
      tick();
    end
    @(negedge clk); chk("t6_stall_addr", fifo_cmd_addr, 27'h60);
    tick(); fifo_cmd_ready = 1'b1;
    wait_b(4'd9, 2'b00);

    r_q.delete(); axi.rready = 1'b0;
    rsp_q.push_back(128'hF1F1F1F1F1F1F1F1_F0F0F0F0F0F0F0F0);
    set_ar(4'd10, 32'h700, 8'd1); wait_ar();
    wait_rvalid(); tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_r0_hold", {axi.rvalid, axi.rlast, axi.rdata}, {2'b10, 64'hF0F0F0F0F0F0F0F0});
      tick();
    end
    axi.rready = 1'b1; tick(); axi.rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_r1_hold", {axi.rvalid, axi.rlast, axi.rdata}, {2'b11, 64'hF1F1F1F1F1F1F1F1});
      tick();
    end
    axi.rready = 1'b1;
    wait_r(2);

    set_aw(4'd11, 32'h800, 8'd3, 2'b01); wait_aw();
    send_w(wd[0], 8'hFF, 1'b0);
    @(negedge clk); chk("t6_pre_rst_wready", axi.wready, 1);
    tick(); rst = 1'b1; tick();
    @(negedge clk);
    chk("t6_rst_wready", axi.wready, 0); chk("t6_rst_cmd_valid", fifo_cmd_valid, 0);
    chk("t6_rst_bvalid", axi.bvalid, 0); chk("t6_rst_awready", axi.awready, 0);
    tick(); rst = 1'b0; tick();

    axi.rready = 1'b0;
    rsp_q.push_back(128'h1);
    set_ar(4'd12, 32'h900, 8'd1); wait_ar();
    wait_rvalid(); tick(); rst = 1'b1; tick();
    @(negedge clk);
    chk("t6_rst_rvalid", axi.rvalid, 0); chk("t6_rst_rdata", axi.rdata, 0);
    chk("t6_rst_rsp_ready", fifo_rsp_ready, 0);
    tick(); rst = 1'b0; rsp_q.delete(); axi.rready = 1'b1; tick(); tick();

    cmd_q.delete();
    set_aw(4'd13, 32'h1000, 8'd0, 2'b01); wait_aw();
    send_w(wd[2], 8'hFF, 1'b1); wait_b(4'd13, 2'b00);
    chk("t6_post_ncmd", cmd_q.size(), 1);
    chk("t6_post_addr", cmd_q[0].addr, 27'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
